// File: rtl/sdram_cmd_exec.sv
// SDRAM command executor: registers one accepted command onto the pins, then holds NOP until its
// timing window closes and pulses cmd_done. Optional dropped-request flag via SDRAM_CMD_ERR_EN.
module sdram_cmd_exec #(
  parameter int unsigned CLK_FREQ = 100,
  parameter int unsigned AW       = 12,
  parameter int unsigned BW       = 2,
  parameter int unsigned T_RP     = 20,
  parameter int unsigned T_RFC    = 70,
  parameter int unsigned T_RCD    = 20,
  parameter int unsigned T_MRD    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [3:0]    req_cmd,
  input  logic [AW-1:0] req_addr,
  input  logic [BW-1:0] req_ba,
  output logic          cmd_wip,
  output logic          cmd_done,
`ifdef SDRAM_CMD_ERR_EN
  output logic          cmd_err,
`endif
  output logic          sdram_cke,
  output logic          sdram_cs_n,
  output logic          sdram_ras_n,
  output logic          sdram_cas_n,
  output logic          sdram_we_n,
  output logic [AW-1:0] sdram_addr,
  output logic [BW-1:0] sdram_ba
);

  localparam logic [3:0] CmdDesl = 4'b1111;
  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdAct  = 4'b0011;
  localparam logic [3:0] CmdPre  = 4'b0010;
  localparam logic [3:0] CmdRef  = 4'b0001;
  localparam logic [3:0] CmdLmr  = 4'b0000;

  localparam int unsigned NRpRaw  = (T_RP * CLK_FREQ + 999) / 1000;
  localparam int unsigned NRfcRaw = (T_RFC * CLK_FREQ + 999) / 1000;
  localparam int unsigned NRcdRaw = (T_RCD * CLK_FREQ + 999) / 1000;
  localparam int unsigned NRp     = (NRpRaw < 1) ? 1 : NRpRaw;
  localparam int unsigned NRfc    = (NRfcRaw < 1) ? 1 : NRfcRaw;
  localparam int unsigned NRcd    = (NRcdRaw < 1) ? 1 : NRcdRaw;
  localparam int unsigned NMrd    = (T_MRD < 1) ? 1 : T_MRD;
  localparam int unsigned NMax01  = (NRp > NRfc) ? NRp : NRfc;
  localparam int unsigned NMax23  = (NRcd > NMrd) ? NRcd : NMrd;
  localparam int unsigned NMax    = (NMax01 > NMax23) ? NMax01 : NMax23;
  localparam int unsigned CW      = $clog2(NMax + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   n_m1;
  logic [3:0]      cmd_q, cmd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   ba_q, ba_d;
  logic            cke_q;
  logic            issuable;
  logic            accept;

  always_comb begin
    issuable = ~req_cmd[3] & (req_cmd != CmdNop);
    cmd_wip  = (state_q == StBusy) & (cnt_q != '0);
    cmd_done = (state_q == StBusy) & (cnt_q == '0);
    accept   = req_valid & ~cmd_wip & issuable;

    case (req_cmd)
      CmdPre:  n_m1 = CW'(NRp - 1);
      CmdRef:  n_m1 = CW'(NRfc - 1);
      CmdLmr:  n_m1 = CW'(NMrd - 1);
      CmdAct:  n_m1 = CW'(NRcd - 1);
      default: n_m1 = '0;
    endcase

    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = CmdNop;
    addr_d  = '0;
    ba_d    = '0;

    if (state_q == StBusy) begin
      if (cnt_q == '0) begin
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    // Non-issuable requests (NOP/DESL) pass straight through to the pins when not busy.
    if (req_valid & ~cmd_wip) begin
      cmd_d  = req_cmd;
      addr_d = req_addr;
      ba_d   = req_ba;
    end

    if (accept) begin
      state_d = StBusy;
      cnt_d   = n_m1;
    end
  end

`ifdef SDRAM_CMD_ERR_EN
  assign cmd_err = req_valid & issuable & cmd_wip;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cmd_q   <= CmdDesl;
      addr_q  <= '0;
      ba_q    <= '0;
      cke_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      cke_q   <= 1'b1;
    end
  end

  assign sdram_cke = cke_q;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_addr = addr_q;
  assign sdram_ba   = ba_q;

endmodule
